cache_req_master: RTL and testbench

CACHE_REQ_MASTER -- requirements
Module: cache_req_master

---
 rtl/cache_pkg.sv | 16 +
 rtl/cmd_fifo.sv | 45 ++++
 rtl/cache_req_master.sv | 113 +++++++++++
 tb/tb_cache_req_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and the queued command layout for the
// cache request master.
package cache_pkg;
  localparam int ADDR_W  = 10;
  localparam int WDATA_W = 8;
  localparam int LINE_W  = 32;
  localparam int CMD_W   = 1 + ADDR_W + WDATA_W;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  typedef struct packed {
    logic               write;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO. The occupancy count carries one extra bit so that full and
// empty are distinct. Pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  // full is taken from the registered count, so a same-cycle pop never opens room
  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cache_req_master.sv
// Queues read/write commands and issues them one at a time to the cache.
// Each request is followed by a GAP cycle, and a stalled request is abandoned after TIMEOUT cycles.
module cache_req_master
  import cache_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [WDATA_W-1:0] cmd_wdata,
  output logic               proc_read_req,
  output logic               proc_write_req,
  output logic [ADDR_W-1:0]  proc_address,
  output logic [WDATA_W-1:0] proc_write_data,
  input  logic [LINE_W-1:0]  cache_read_data,
  input  logic               cache_read_ready,
  input  logic               cache_write_ready,
  output logic               rsp_valid,
  output logic [LINE_W-1:0]  rsp_data,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic               wr_done,
  output logic               rsp_timeout,
  output logic               busy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  cmd_t          head, cmd_q;
  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] wait_cnt;
  logic          hit, expire;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   ({cmd_write, cmd_addr, cmd_wdata}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready       = !fifo_full;
  assign hit             = cmd_q.write ? cache_write_ready : cache_read_ready;
  assign expire          = wait_cnt == CW'(TIMEOUT - 1);
  assign proc_read_req   = (state == REQ) && !cmd_q.write;
  assign proc_write_req  = (state == REQ) && cmd_q.write;
  assign proc_address    = cmd_q.addr;
  assign proc_write_data = cmd_q.wdata;
  assign busy            = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = REQ;
      end
      REQ:     if (hit || expire) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A matching ready on the last allowed cycle still counts as a completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q       <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      wr_done     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      wr_done     <= 1'b0;
      rsp_timeout <= 1'b0;
      if (pop) begin
        cmd_q.write <= head.write;
        cmd_q.addr  <= head.addr;
        cmd_q.wdata <= head.write ? head.wdata : '0;
        wait_cnt    <= '0;
      end
      if (state == REQ) begin
        if (hit) begin
          rsp_valid <= !cmd_q.write;
          wr_done   <= cmd_q.write;
          if (!cmd_q.write) begin
            rsp_data <= cache_read_data;
            rsp_addr <= cmd_q.addr;
          end
        end else if (expire) begin
          rsp_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_req_master.sv
// Bench for cache_req_master: a latency-programmable cache responder, a bus
// monitor that turns each request into a record, and a queue model of expected outcomes.
module tb_cache_req_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        proc_read_req, proc_write_req;
  logic [9:0]  proc_address;
  logic [7:0]  proc_write_data;
  logic [31:0] cache_read_data = '0;
  logic        cache_read_ready = 1'b0, cache_write_ready = 1'b0;
  logic        rsp_valid, wr_done, rsp_timeout, busy;
  logic [31:0] rsp_data;
  logic [9:0]  rsp_addr;

  cache_req_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .proc_read_req(proc_read_req), .proc_write_req(proc_write_req),
    .proc_address(proc_address), .proc_write_data(proc_write_data),
    .cache_read_data(cache_read_data), .cache_read_ready(cache_read_ready),
    .cache_write_ready(cache_write_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .wr_done(wr_done),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // lat = request cycles until the responder answers; lat > TMO means never
  typedef struct {
    logic wr; logic [9:0] addr; logic [7:0] wdata;
    int lat; logic stray; logic [31:0] line;
  } tcmd_t;
  // outcome: 0 none, 1 rsp_valid, 2 wr_done, 3 rsp_timeout, 7 several pulses
  typedef struct {
    logic wr; logic [9:0] addr; logic [7:0] data; int hi; logic stable;
    int outcome; logic [31:0] rdata; logic [9:0] raddr;
  } obs_t;

  tcmd_t rsp_q[$], exp_q[$];
  obs_t  obs_q[$];
  int    total = 0, passed = 0;
  logic  resp_en = 1'b1;

  tcmd_t cur_r;
  int    r_hi = 0;
  always @(negedge clk) begin
    cache_read_ready  = 1'b0;
    cache_write_ready = 1'b0;
    cache_read_data   = $urandom;
    if (!rst) r_hi = 0;
    else if (proc_read_req || proc_write_req) begin
      if (r_hi == 0) begin
        if (rsp_q.size() > 0) cur_r = rsp_q.pop_front();
        else cur_r.lat = 1000;
      end
      r_hi++;
      if (cur_r.stray && r_hi == 1) begin
        if (proc_read_req) cache_write_ready = 1'b1;
        else               cache_read_ready  = 1'b1;
      end
      if (resp_en && r_hi >= cur_r.lat) begin
        if (proc_read_req) begin
          cache_read_ready = 1'b1;
          cache_read_data  = cur_r.line;
        end else cache_write_ready = 1'b1;
      end
    end else r_hi = 0;
  end

  obs_t        cur;
  logic        act, act_prev = 1'b0;
  int          pulses, stray_cnt = 0, hold_err = 0, both_err = 0;
  logic [31:0] last_d = '0;
  logic [9:0]  last_a = '0;
  always @(negedge clk) begin
    if (!rst) begin
      act_prev = 1'b0; last_d = '0; last_a = '0;
    end else begin
      act    = proc_read_req | proc_write_req;
      pulses = int'(rsp_valid) + int'(wr_done) + int'(rsp_timeout);
      if (proc_read_req && proc_write_req) both_err++;
      if (act && !act_prev) begin
        cur.wr = proc_write_req; cur.addr = proc_address; cur.data = proc_write_data;
        cur.hi = 1; cur.stable = 1'b1;
      end else if (act) begin
        cur.hi++;
        if (proc_address !== cur.addr || proc_write_data !== cur.data || proc_write_req !== cur.wr)
          cur.stable = 1'b0;
      end
      if (!act && act_prev) begin
        cur.outcome = pulses > 1 ? 7 : rsp_valid ? 1 : wr_done ? 2 : rsp_timeout ? 3 : 0;
        cur.rdata = rsp_data; cur.raddr = rsp_addr;
        obs_q.push_back(cur);
      end else if (pulses != 0) stray_cnt++;
      if (rsp_valid) begin
        last_d = rsp_data; last_a = rsp_addr;
      end else if (rsp_data !== last_d || rsp_addr !== last_a) hold_err++;
      act_prev = act;
    end
  end

  task automatic push_cmd(input tcmd_t c);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.addr; cmd_wdata = c.wdata;
    rsp_q.push_back(c); exp_q.push_back(c);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; $display("FAIL push_accept: cmd_ready stuck low for %0d cycles", n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while ((obs_q.size() < n || busy) && k < 3000) begin @(negedge clk); k++; end
    total++;
    if (obs_q.size() != n || busy)
      $display("FAIL drain: got %0d requests busy=%b, want %0d idle", obs_q.size(), busy, n);
    else passed++;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!(proc_read_req || proc_write_req) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin total++; $display("FAIL wait_req: no request within 50 cycles"); end
  endtask

  task automatic clear_q();
    obs_q.delete(); exp_q.delete(); rsp_q.delete();
  endtask

  function automatic tcmd_t mk(input logic wr, input logic [9:0] a, input logic [7:0] d,
                               input int lat, input logic stray, input logic [31:0] line);
    tcmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.lat = lat; c.stray = stray; c.line = line;
    return c;
  endfunction

  task automatic test_reset();
    #3;
    total++;
    if ({proc_read_req, proc_write_req, proc_address, proc_write_data} !== 20'h0)
      $display("FAIL reset_req: got rd=%b wr=%b a=%h d=%h, want all 0",
               proc_read_req, proc_write_req, proc_address, proc_write_data);
    else passed++;
    total++;
    if ({rsp_valid, wr_done, rsp_timeout, rsp_data, rsp_addr} !== 45'h0)
      $display("FAIL reset_rsp: got v=%b wd=%b to=%b d=%h a=%h, want all 0",
               rsp_valid, wr_done, rsp_timeout, rsp_data, rsp_addr);
    else passed++;
    total++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset_flags: got busy=%b cmd_ready=%b, want 0/1", busy, cmd_ready);
    else passed++;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    push_cmd(mk(1'b1, 10'h001, 8'hFF, 3, 1'b0, 32'h0));
    drain(1);
    if (obs_q.size() == 1) begin
      total++;
      if (obs_q[0].wr !== 1'b1 || obs_q[0].addr !== 10'h001 || obs_q[0].data !== 8'hFF || !obs_q[0].stable)
        $display("FAIL write_req: got wr=%b a=%h d=%h stable=%b, want 1/001/ff/1",
                 obs_q[0].wr, obs_q[0].addr, obs_q[0].data, obs_q[0].stable);
      else passed++;
      total++;
      if (obs_q[0].hi != 3 || obs_q[0].outcome != 2)
        $display("FAIL write_done: got hi=%0d outcome=%0d, want 3/2", obs_q[0].hi, obs_q[0].outcome);
      else passed++;
    end
    clear_q();
  endtask

  task automatic test_read();
    push_cmd(mk(1'b0, 10'h001, 8'h77, 5, 1'b0, 32'h0000_00FF));
    drain(1);
    if (obs_q.size() == 1) begin
      total++;
      if (obs_q[0].outcome != 1 || obs_q[0].rdata !== 32'hFF || obs_q[0].raddr !== 10'h001 ||
          obs_q[0].hi != 5 || obs_q[0].data !== 8'h00)
        $display("FAIL read_rsp: got out=%0d d=%h a=%h hi=%0d wd=%h, want 1/000000ff/001/5/00",
                 obs_q[0].outcome, obs_q[0].rdata, obs_q[0].raddr, obs_q[0].hi, obs_q[0].data);
      else passed++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (rsp_data !== 32'hFF || rsp_addr !== 10'h001)
      $display("FAIL read_hold: got d=%h a=%h, want 000000ff/001", rsp_data, rsp_addr);
    else passed++;
    clear_q();
  endtask

  task automatic test_stray();
    push_cmd(mk(1'b0, 10'h2A5, 8'h00, 4, 1'b1, 32'hDEAD_BEEF));
    drain(1);
    if (obs_q.size() == 1) begin
      total++;
      if (obs_q[0].outcome != 1 || obs_q[0].hi != 4 || obs_q[0].rdata !== 32'hDEADBEEF)
        $display("FAIL stray_ready: got out=%0d hi=%0d d=%h, want 1/4/deadbeef",
                 obs_q[0].outcome, obs_q[0].hi, obs_q[0].rdata);
      else passed++;
    end
    clear_q();
  endtask

  task automatic test_timeout();
    push_cmd(mk(1'b0, 10'h003, 8'h00, 1000, 1'b0, 32'h0));
    push_cmd(mk(1'b1, 10'h004, 8'h5A, 2, 1'b0, 32'h0));
    drain(2);
    if (obs_q.size() == 2) begin
      total++;
      if (obs_q[0].wr !== 1'b0 || obs_q[0].hi != TMO || obs_q[0].outcome != 3)
        $display("FAIL timeout_drop: got wr=%b hi=%0d out=%0d, want 0/%0d/3",
                 obs_q[0].wr, obs_q[0].hi, obs_q[0].outcome, TMO);
      else passed++;
      total++;
      if (obs_q[1].wr !== 1'b1 || obs_q[1].addr !== 10'h004 || obs_q[1].data !== 8'h5A || obs_q[1].outcome != 2)
        $display("FAIL timeout_next: got wr=%b a=%h d=%h out=%0d, want 1/004/5a/2",
                 obs_q[1].wr, obs_q[1].addr, obs_q[1].data, obs_q[1].outcome);
      else passed++;
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    int ho, oo;
    resp_en = 1'b0;
    push_cmd(mk(1'b0, 10'h100, 8'h00, 2, 1'b0, 32'h1234_5678));
    wait_req();
    // FSM is parked in REQ, so four pushes fill the FIFO
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cmd_ready !== 1'b1) $display("FAIL full_ready_%0d: got cmd_ready=%b, want 1", i, cmd_ready);
      else passed++;
      push_cmd(mk(1'($urandom), 10'(i + 10'h200), 8'($urandom), int'($urandom_range(1, 4)), 1'b0, $urandom));
    end
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL full_ready_low: got cmd_ready=%b, want 0", cmd_ready);
    else passed++;
    resp_en = 1'b1;
    push_cmd(mk(1'b1, 10'h3FF, 8'hC3, 1, 1'b0, 32'h0));
    drain(6);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      oo = exp_q[i].lat <= TMO ? (exp_q[i].wr ? 2 : 1) : 3;
      ho = exp_q[i].lat <= TMO ? exp_q[i].lat : TMO;
      total++;
      if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr || !obs_q[i].stable ||
          obs_q[i].data !== (exp_q[i].wr ? exp_q[i].wdata : 8'h00) || obs_q[i].outcome != oo ||
          (i > 0 && obs_q[i].hi != ho) || (oo == 1 && obs_q[i].rdata !== exp_q[i].line))
        $display("FAIL order_%0d: got wr=%b a=%h d=%h hi=%0d out=%0d rd=%h, want wr=%b a=%h hi=%0d out=%0d rd=%h",
                 i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data, obs_q[i].hi, obs_q[i].outcome,
                 obs_q[i].rdata, exp_q[i].wr, exp_q[i].addr, ho, oo, exp_q[i].line);
      else passed++;
    end
    clear_q();
  endtask

  task automatic test_random();
    int ho, oo;
    for (int i = 0; i < 20; i++) begin
      push_cmd(mk(1'($urandom), 10'($urandom), 8'($urandom), int'($urandom_range(1, 11)),
                  $urandom_range(0, 3) == 0, $urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain(20);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      oo = exp_q[i].lat <= TMO ? (exp_q[i].wr ? 2 : 1) : 3;
      ho = exp_q[i].lat <= TMO ? exp_q[i].lat : TMO;
      total++;
      if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr || !obs_q[i].stable ||
          obs_q[i].data !== (exp_q[i].wr ? exp_q[i].wdata : 8'h00) || obs_q[i].outcome != oo ||
          obs_q[i].hi != ho || (oo == 1 && (obs_q[i].rdata !== exp_q[i].line || obs_q[i].raddr !== exp_q[i].addr)))
        $display("FAIL rand_%0d: got wr=%b a=%h d=%h hi=%0d out=%0d rd=%h, want wr=%b a=%h hi=%0d out=%0d rd=%h",
                 i, obs_q[i].wr, obs_q[i].addr, obs_q[i].data, obs_q[i].hi, obs_q[i].outcome,
                 obs_q[i].rdata, exp_q[i].wr, exp_q[i].addr, ho, oo, exp_q[i].line);
      else passed++;
    end
    total++;
    if (stray_cnt != 0 || hold_err != 0 || both_err != 0)
      $display("FAIL pulse_hygiene: got stray=%0d hold_err=%0d both=%0d, want 0/0/0", stray_cnt, hold_err, both_err);
    else passed++;
    clear_q();
  endtask

  task automatic test_reset_mid();
    push_cmd(mk(1'b0, 10'h0AA, 8'h00, 1000, 1'b0, 32'h0));
    wait_req();
    push_cmd(mk(1'b1, 10'h0BB, 8'h11, 1, 1'b0, 32'h0));
    push_cmd(mk(1'b0, 10'h0CC, 8'h00, 1, 1'b0, 32'h0));
    #2 rst = 1'b0;
    #1;
    total++;
    if (proc_read_req !== 1'b0 || proc_write_req !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL midreset_now: got rd=%b wr=%b busy=%b ready=%b, want 0/0/0/1",
               proc_read_req, proc_write_req, busy, cmd_ready);
    else passed++;
    clear_q();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || busy !== 1'b0 || stray_cnt != 0)
      $display("FAIL midreset_after: got requests=%0d busy=%b stray=%0d, want 0/0/0", obs_q.size(), busy, stray_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stray();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
